lifo_drain: RTL and testbench
=============================

LIFO_DRAIN -- requirements
Module: lifo_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of stack entries and output data.
REQ-002 Parameter DEPTH, default 16: maximum stack depth; CNT_W = $clog2(DEPTH)+1.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 start  input  1  request to begin a drain burst; sampled only in IDLE.
REQ-006 burst_len  input  CNT_W  number of entries to pop; 0 means pop until the stack is empty; latched on accepted start.
REQ-007 lifo_empty  input  1  empty flag from the upstream stack.
REQ-008 lifo_data  input  DATA_WIDTH  stack data_out; valid the cycle after lifo_rd_enable is high.
REQ-009 lifo_rd_enable  output  1  pop strobe to the stack; registered Moore output.
REQ-010 out_data  output  DATA_WIDTH  popped entry presented downstream.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle pulse at the end of each burst.
REQ-015 pop_count  output  CNT_W  entries handed downstream in the current or most recent burst.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, READ, LOAD, SEND, DONE.
REQ-017 IDLE: start=1 -> latch burst_len into remaining, clear pop_count, go CHECK; start=0 -> stay.
REQ-018 CHECK: lifo_empty=1, or burst_len was nonzero and remaining==0 -> DONE; otherwise -> READ.
REQ-019 READ: lifo_rd_enable=1 for exactly this one cycle, then LOAD unconditionally.
REQ-020 LOAD: register lifo_data into out_data, then SEND.
REQ-021 SEND: out_valid=1; out_data SHALL be held stable until out_valid&&out_ready.
REQ-022 SEND handshake: pop_count+1, remaining-1 (only when burst_len nonzero), go CHECK.
REQ-023 DONE: done=1 for one cycle, then IDLE; pop_count holds until the next accepted start.
REQ-024 lifo_rd_enable SHALL never be high outside READ and SHALL never be high while lifo_empty=1 was sampled in the preceding CHECK.
REQ-025 Throughput: at most one entry per 4 cycles (CHECK, READ, LOAD, SEND with out_ready=1).
REQ-026 start while busy SHALL be ignored and SHALL NOT alter remaining or pop_count.
REQ-027 pop_count SHALL saturate at DEPTH and SHALL NOT wrap.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 With empty stack at start: done SHALL pulse 2 cycles after start is sampled (IDLE->CHECK->DONE), with no lifo_rd_enable.
REQ-030 burst_len > stack occupancy: the burst SHALL end on lifo_empty without error; pop_count equals the entries actually popped.

Reset
REQ-031 reset low SHALL immediately force state IDLE, lifo_rd_enable=0, out_valid=0, out_data=0, busy=0, done=0, pop_count=0, remaining=0.
REQ-032 reset mid-burst SHALL discard any entry held in out_data; the stack is not restored by this block.
REQ-033 After reset release, the first start SHALL be accepted on the first rising edge with reset high.

Verification
REQ-034 Push 0A,0B,0C,0D; start, burst_len=0, out_ready=1 -> out_data sequence 0D,0C,0B,0A; 4 lifo_rd_enable pulses; done once; pop_count=4.
REQ-035 Same stack, burst_len=2 -> 0D,0C delivered; done; pop_count=2; stack still holds 0B,0A (next burst yields 0B,0A).
REQ-036 Backpressure: out_ready=0 for 5 cycles in SEND -> out_valid stays 1, out_data constant, no extra lifo_rd_enable; release -> next entry follows.
REQ-037 Empty stack, start -> done 2 cycles later, pop_count=0, lifo_rd_enable never high.
REQ-038 start pulses during busy -> ignored; burst result identical to REQ-034.
REQ-039 reset low while in SEND with out_data=0C -> all outputs 0 asynchronously, busy=0; after release, new start drains remaining entries.

Source files
------------

// File: rtl/lifo_drain.sv
// Drains a burst of entries from an upstream LIFO and hands them downstream
// one at a time over a valid/ready handshake.
module lifo_drain #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    input  logic                  lifo_empty,
    input  logic [DATA_WIDTH-1:0] lifo_data,
    output logic                  lifo_rd_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pop_count
);

    typedef enum logic [2:0] {IDLE, CHECK, READ, LOAD, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0]      pop_count_q, pop_count_d;
    logic                  len_nz_q, len_nz_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  rd_en_q, rd_en_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pop_count_d = pop_count_q;
        len_nz_d    = len_nz_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    len_nz_d    = |burst_len;
                    pop_count_d = '0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                // A zero burst length means "until empty", so remaining is ignored.
                if (lifo_empty || (len_nz_q && remaining_q == '0))
                    state_d = DONE;
                else
                    state_d = READ;
            end
            READ: state_d = LOAD;
            LOAD: begin
                out_data_d = lifo_data;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (pop_count_q != CNT_W'(DEPTH))
                        pop_count_d = pop_count_q + CNT_W'(1);
                    if (len_nz_q)
                        remaining_d = remaining_q - CNT_W'(1);
                    state_d = CHECK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered against the next state so they align with it.
        rd_en_d     = (state_d == READ);
        out_valid_d = (state_d == SEND);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pop_count_q <= '0;
            len_nz_q    <= 1'b0;
            out_data_q  <= '0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pop_count_q <= pop_count_d;
            len_nz_q    <= len_nz_d;
            out_data_q  <= out_data_d;
            rd_en_q     <= rd_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign lifo_rd_enable = rd_en_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pop_count      = pop_count_q;

endmodule

// File: tb/tb_lifo_drain.sv
// Bench for lifo_drain: behavioural upstream stack, per-burst expected pop order
// computed from the stack contents, plus protocol monitors.
module tb_lifo_drain;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             lifo_empty;
    logic [DW-1:0]    lifo_data = '0;
    logic             lifo_rd_enable;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [64];
    int            sp = 0;
    logic [DW-1:0] got [$];
    int            rd_cnt = 0;
    int            done_cnt = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;

    always #5 clk = ~clk;

    lifo_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .lifo_empty(lifo_empty), .lifo_data(lifo_data),
        .lifo_rd_enable(lifo_rd_enable), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .pop_count(pop_count)
    );

    // Upstream stack: data_out registered one cycle after the pop strobe.
    assign lifo_empty = (sp == 0);
    always @(posedge clk) begin
        if (lifo_rd_enable && sp > 0) begin
            sp = sp - 1;
            lifo_data <= mem[sp];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            hold_q = 1'b0;
        end else begin
            if (lifo_rd_enable) begin
                rd_cnt++;
                vectors++;
                assert (!lifo_empty && !out_valid) else begin
                    miscompares++;
                    $error("FAIL rd_gate: rd_en=1 empty=%b valid=%b, required empty=0 valid=0", lifo_empty, out_valid);
                end
            end
            if (done) done_cnt++;
            if (hold_q) begin
                vectors++;
                assert (out_valid === 1'b1 && out_data === hold_data) else begin
                    miscompares++;
                    $error("FAIL hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, hold_data);
                end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            hold_q    = out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[sp] = d;
        sp = sp + 1;
    endtask

    task automatic push_abcd();
        push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
    endtask

    // Called in the posedge+1 phase. mode: 0 ready=1, 1 random ready,
    // 2 ready=1 with random start/burst_len noise while busy, 3 ready low for 8 cycles.
    task automatic run_burst(input int len, input int mode);
        int n;
        int cyc;
        logic [DW-1:0] exp_q [$];
        n = (len == 0 || len > sp) ? sp : len;
        exp_q = {};
        for (int i = 0; i < n; i++) exp_q.push_back(mem[sp-1-i]);
        got = {};
        rd_cnt = 0;
        done_cnt = 0;
        burst_len = CNT_W'(len);
        start = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 3 ? 1'b0 : 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 600) begin
            @(negedge clk);
            if (done_cnt != 0) break;
            @(posedge clk); #1;
            cyc++;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    start = 1'($urandom_range(0, 1));
                    burst_len = CNT_W'($urandom_range(0, 31));
                end
                3: out_ready = (cyc >= 8);
                default: ;
            endcase
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("rd_pulses", 32'(rd_cnt), 32'(n));
        chk("got_count", 32'(got.size()), 32'(n));
        chk("pop_count", 32'(pop_count), 32'((n > DEPTH) ? DEPTH : n));
        for (int i = 0; i < n; i++)
            chk($sformatf("data[%0d]", i), (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!out_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_rd", 32'(lifo_rd_enable), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_popcnt", 32'(pop_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        push_abcd(); run_burst(0, 0);
        push_abcd(); run_burst(2, 0); run_burst(0, 0);
        push(8'h31); push(8'h32); push(8'h33); run_burst(0, 3);

        // Empty stack: DONE two edges after start is sampled, no pops.
        sp = 0; rd_cnt = 0; done_cnt = 0;
        burst_len = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("empty_chk_done", 32'(done), 32'd0);
        chk("empty_chk_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("empty_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("empty_done_clr", 32'(done), 32'd0);
        chk("empty_busy_clr", 32'(busy), 32'd0);
        chk("empty_popcnt", 32'(pop_count), 32'd0);
        chk("empty_rd", 32'(rd_cnt), 32'd0);
        @(posedge clk); #1;

        push_abcd(); run_burst(0, 2);
        for (int i = 0; i < 20; i++) push(DW'($urandom));
        run_burst(0, 0);
        push(8'h51); push(8'h52); push(8'h53); run_burst(7, 1);
        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(0, 6);
            for (int i = 0; i < k; i++) push(DW'($urandom));
            run_burst($urandom_range(0, 8), $urandom_range(0, 3));
        end
        sp = 0;

        // Reset mid-burst while 0C sits in SEND.
        push_abcd();
        burst_len = '0; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_valid("mid_first_valid");
        chk("mid_first_data", 32'(out_data), 32'h0D);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        wait_valid("mid_second_valid");
        chk("mid_second_data", 32'(out_data), 32'h0C);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_popcnt", 32'(pop_count), 32'd0);
        chk("arst_rd", 32'(lifo_rd_enable), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        run_burst(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
